// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_arb_pkg
// Description : Shared types and helpers for the AXIS packet arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

    localparam int PKT_CNT_W = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    // A one-bit ID is still needed when there are only two (or one) sources.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker (rotate, priority-encode,
//               un-rotate) starting the search at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int ID_WIDTH = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN-1:0]   req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                found,
    output logic [ID_WIDTH-1:0] idx
);

    logic [NUM_IN-1:0]   w_rot;
    logic [ID_WIDTH-1:0] w_off;
    int                  w_sum;

    always_comb begin
        w_rot = '0;
        w_off = '0;
        w_sum = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_rot[i] = req[(i + int'(ptr)) % NUM_IN];
        end
        // Scan downward so the lowest set bit of the rotated vector wins.
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = ID_WIDTH'(i);
            end
        end
        w_sum = int'(w_off) + int'(ptr);
        if (w_sum >= NUM_IN) begin
            w_sum = w_sum - NUM_IN;
        end
        found = |req;
        idx   = ID_WIDTH'(w_sum);
    end

endmodule
`default_nettype wire

// File: rtl/axis_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_packet_arbiter
// Description : Packet-locked round-robin AXIS arbiter with registered master
//               output, source ID tagging and completed-packet counter.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IN     = 4,
    parameter int ID_WIDTH   = clog2_min1(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_IN-1:0]            s_tvalid,
    input  logic [NUM_IN-1:0]            s_tlast,
    output logic [NUM_IN-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    input  logic                         m_tready,
    output logic [ID_WIDTH-1:0]          m_tid,
    input  logic [NUM_IN-1:0]            en_mask,
    output logic                         busy,
    output logic [PKT_CNT_W-1:0]         pkt_count
);

    arb_state_t             state_q, state_d;
    logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]    gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
    logic                   m_tlast_q, m_tlast_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic [ID_WIDTH-1:0]    m_tid_q, m_tid_d;
    logic [PKT_CNT_W-1:0]   pkt_count_q, pkt_count_d;

    logic                   w_found;
    logic [ID_WIDTH-1:0]    w_idx;
    logic                   w_gnt_ready;
    logic                   w_load;
    logic [DATA_WIDTH-1:0]  w_sel_data;

    rr_pick #(
        .NUM_IN   (NUM_IN),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req   (s_tvalid & en_mask),
        .ptr   (ptr_q),
        .found (w_found),
        .idx   (w_idx)
    );

    // The output register can accept whenever it is empty or draining this cycle.
    assign w_gnt_ready = !m_tvalid_q || m_tready;
    assign w_sel_data  = s_tdata[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
    assign w_load      = (state_q == ACTIVE) && s_tvalid[gnt_q] && w_gnt_ready;

    always_comb begin
        s_tready = '0;
        if (state_q == ACTIVE) begin
            s_tready[gnt_q] = w_gnt_ready;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        m_tdata_d   = m_tdata_q;
        m_tlast_d   = m_tlast_q;
        m_tvalid_d  = m_tvalid_q;
        m_tid_d     = m_tid_q;
        pkt_count_d = pkt_count_q;

        case (state_q)
            IDLE: begin
                if (w_found) begin
                    gnt_d   = w_idx;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_load && s_tlast[gnt_q]) begin
                    state_d = IDLE;
                    ptr_d   = (gnt_q == ID_WIDTH'(NUM_IN - 1)) ? '0 : gnt_q + ID_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_load) begin
            m_tdata_d  = w_sel_data;
            m_tlast_d  = s_tlast[gnt_q];
            m_tid_d    = gnt_q;
            m_tvalid_d = 1'b1;
        end else if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end

        if (m_tvalid_q && m_tready && m_tlast_q) begin
            pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            m_tdata_q   <= '0;
            m_tlast_q   <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tid_q     <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            m_tdata_q   <= m_tdata_d;
            m_tlast_q   <= m_tlast_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tid_q     <= m_tid_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign m_tdata   = m_tdata_q;
    assign m_tlast   = m_tlast_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tid     = m_tid_q;
    assign pkt_count = pkt_count_q;
    assign busy      = (state_q == ACTIVE) || m_tvalid_q;

endmodule
`default_nettype wire
